// File: rtl/acc_pkg.sv
// Shared types and default sizes for the accumulator datapath stages.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    localparam int ACC_W      = 8;
    localparam int BCD_DIGITS = 3;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import acc_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/acc_bcd_converter.sv
// Captures an accumulator sample and converts it to sign + packed BCD with a
// sequential shift-add-3 FSM; the result holds until the next conversion.
//
// state | meaning
// IDLE  | waiting for start_i; sample captured on the accepting edge
// SHIFT | one add-3/shift iteration per clock, W iterations
// DONE  | result registers just updated; done_o high for this one cycle
module acc_bcd_converter
    import acc_pkg::*;
#(
    parameter int W         = ACC_W,
    parameter int DIGITS    = BCD_DIGITS,
    parameter int SIGNED_IN = 1
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [W-1:0]          data_i,
    input  logic                  cout_i,
    input  logic                  v_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sign_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  carry_o,
    output logic                  ovf_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(W + 1);

    conv_state_e      state_q;
    conv_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     mag_q;
    logic [W-1:0]     mag_next;
    logic [BCD_W-1:0] dig_q;
    logic [BCD_W-1:0] dig_adj;
    logic [BCD_W-1:0] dig_next;
    logic             sign_cap;
    logic             carry_cap;
    logic             ovf_cap;
    logic             neg_in;
    logic             last_iter;

    // -0x80 wraps back to 0x80, which read unsigned is the correct magnitude 128
    assign neg_in    = (SIGNED_IN != 0) && data_i[W-1];
    assign last_iter = (cnt_q == CNT_W'(W - 1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig_q[4*g +: 4]),
            .dout (dig_adj[4*g +: 4])
        );
    end

    assign {dig_next, mag_next} = {dig_adj, mag_q} << 1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SHIFT;
            SHIFT:   if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            dig_q     <= '0;
            sign_cap  <= 1'b0;
            carry_cap <= 1'b0;
            ovf_cap   <= 1'b0;
            sign_o    <= 1'b0;
            bcd_o     <= '0;
            carry_o   <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        carry_cap <= cout_i;
                        ovf_cap   <= v_i;
                        sign_cap  <= neg_in;
                        mag_q     <= neg_in ? -data_i : data_i;
                        dig_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                SHIFT: begin
                    mag_q <= mag_next;
                    dig_q <= dig_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // publish on the final iteration so results land with the DONE entry
                    if (last_iter) begin
                        bcd_o   <= dig_next;
                        sign_o  <= sign_cap;
                        carry_o <= carry_cap;
                        ovf_o   <= ovf_cap;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_acc_bcd_converter.sv
// Scoreboard bench: expected results are queued at start and popped at done_o.
module tb_acc_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  data;
    logic        cout;
    logic        v;

    logic        s_busy, s_done, s_sign, s_carry, s_ovf;
    logic [11:0] s_bcd;
    logic        u_busy, u_done, u_sign, u_carry, u_ovf;
    logic [11:0] u_bcd;

    typedef struct {
        logic        sign;
        logic [11:0] bcd;
        logic [11:0] ubcd;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    acc_bcd_converter #(.W(8), .DIGITS(3), .SIGNED_IN(1)) dut_s (
        .clk_i(clk), .rst(rst), .start_i(start), .data_i(data), .cout_i(cout), .v_i(v),
        .busy_o(s_busy), .done_o(s_done), .sign_o(s_sign), .bcd_o(s_bcd),
        .carry_o(s_carry), .ovf_o(s_ovf)
    );

    acc_bcd_converter #(.W(8), .DIGITS(3), .SIGNED_IN(0)) dut_u (
        .clk_i(clk), .rst(rst), .start_i(start), .data_i(data), .cout_i(cout), .v_i(v),
        .busy_o(u_busy), .done_o(u_done), .sign_o(u_sign), .bcd_o(u_bcd),
        .carry_o(u_carry), .ovf_o(u_ovf)
    );

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Start pulse of one cycle; inputs are scrambled afterwards to prove single sampling.
    task automatic drive_start(input logic [7:0] d, input logic c, input logic vv);
        exp_t e;
        int   m;
        @(negedge clk);
        start = 1'b1; data = d; cout = c; v = vv;
        m       = d[7] ? 256 - int'(d) : int'(d);
        e.sign  = d[7];
        e.bcd   = to_bcd(m);
        e.ubcd  = to_bcd(int'(d));
        e.carry = c;
        e.ovf   = vv;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; data = ~d; cout = ~c; v = ~vv;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (s_done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; data = 8'h00; cout = 1'b0; v = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({s_busy, s_done, s_sign, s_carry, s_ovf, s_bcd} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_signed: got %h expected 0", {s_busy, s_done, s_sign, s_carry, s_ovf, s_bcd});
        end
        n_tests++;
        if ({u_busy, u_done, u_sign, u_carry, u_ovf, u_bcd} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_unsigned: got %h expected 0", {u_busy, u_done, u_sign, u_carry, u_ovf, u_bcd});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        exp_t e;
        int   cyc;
        drive_start(8'h7B, 1'b0, 1'b0);
        wait_done(cyc);
        e = sb.pop_front();
        n_tests++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL latency: done after %0d cycles from start cycle, expected 9", cyc + 1);
        end
        n_tests++;
        if (s_bcd !== e.bcd || s_sign !== e.sign) begin
            n_fail++;
            $display("FAIL basic_bcd: got sign=%b bcd=%h expected sign=%b bcd=%h", s_sign, s_bcd, e.sign, e.bcd);
        end
        n_tests++;
        if (s_carry !== e.carry || s_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL basic_flags: got c=%b v=%b expected c=%b v=%b", s_carry, s_ovf, e.carry, e.ovf);
        end
        @(negedge clk);
        n_tests++;
        if (s_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done_o=%b one cycle later, expected 0", s_done);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (s_bcd !== e.bcd || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got bcd=%h busy=%b expected bcd=%h busy=0", s_bcd, s_busy, e.bcd);
        end
    endtask

    task automatic test_sign_magnitude;
        exp_t        e;
        int          cyc;
        logic [7:0]  pats [3];
        pats[0] = 8'hFF; pats[1] = 8'h80; pats[2] = 8'h00;
        for (int p = 0; p < 3; p++) begin
            drive_start(pats[p], 1'b0, 1'b0);
            wait_done(cyc);
            e = sb.pop_front();
            n_tests++;
            if (cyc !== 8) begin
                n_fail++;
                $display("FAIL sm_timeout %h: done at %0d expected 8", pats[p], cyc);
            end
            n_tests++;
            if (s_sign !== e.sign || s_bcd !== e.bcd) begin
                n_fail++;
                $display("FAIL signed_conv %h: got sign=%b bcd=%h expected sign=%b bcd=%h",
                         pats[p], s_sign, s_bcd, e.sign, e.bcd);
            end
            n_tests++;
            if (u_sign !== 1'b0 || u_bcd !== e.ubcd) begin
                n_fail++;
                $display("FAIL unsigned_conv %h: got sign=%b bcd=%h expected sign=0 bcd=%h",
                         pats[p], u_sign, u_bcd, e.ubcd);
            end
            n_tests++;
            if (u_done !== 1'b1) begin
                n_fail++;
                $display("FAIL unsigned_done %h: done_o=%b expected 1", pats[p], u_done);
            end
        end
    endtask

    task automatic test_flags;
        exp_t e;
        int   cyc;
        drive_start(8'h64, 1'b1, 1'b1);
        wait_done(cyc);
        e = sb.pop_front();
        n_tests++;
        if (cyc !== 8 || s_bcd !== e.bcd) begin
            n_fail++;
            $display("FAIL flags_bcd: got bcd=%h at %0d expected bcd=%h at 8", s_bcd, cyc, e.bcd);
        end
        n_tests++;
        if (s_carry !== 1'b1 || s_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL flags_capture: got c=%b v=%b expected c=1 v=1", s_carry, s_ovf);
        end
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        int          busy_cnt;
        int          done_cnt;
        logic [11:0] cap_bcd;
        drive_start(8'h0A, 1'b0, 1'b0);
        busy_cnt = s_busy ? 1 : 0;
        done_cnt = 0;
        cap_bcd  = 12'hFFF;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (s_busy) busy_cnt++;
            if (n == 3) begin
                start = 1'b1; data = 8'h05;
            end
            if (s_done) begin
                if (done_cnt == 0) cap_bcd = s_bcd;
                done_cnt++;
                start = 1'b1; data = 8'h05;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL ignore_start_pulses: got %0d done pulses expected 1", done_cnt);
        end
        n_tests++;
        if (busy_cnt !== 9) begin
            n_fail++;
            $display("FAIL busy_width: busy for %0d cycles expected 9", busy_cnt);
        end
        n_tests++;
        if (cap_bcd !== e.bcd) begin
            n_fail++;
            $display("FAIL ignore_bcd: got %h expected %h", cap_bcd, e.bcd);
        end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        int   cyc;
        int   done_cnt;
        drive_start(8'h7B, 1'b0, 1'b0);
        void'(sb.pop_front());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({s_busy, s_done, s_sign, s_carry, s_ovf, s_bcd} !== 17'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h expected 0", {s_busy, s_done, s_sign, s_carry, s_ovf, s_bcd});
        end
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (s_done) done_cnt++;
        end
        n_tests++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt);
        end
        drive_start(8'h2A, 1'b0, 1'b0);
        wait_done(cyc);
        e = sb.pop_front();
        n_tests++;
        if (cyc !== 8 || s_bcd !== e.bcd || s_sign !== e.sign) begin
            n_fail++;
            $display("FAIL after_abort: got bcd=%h sign=%b at %0d expected bcd=%h sign=%b at 8",
                     s_bcd, s_sign, cyc, e.bcd, e.sign);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_magnitude();
        test_flags();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
